fp_add_pipe: RTL and testbench

//   Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor with

---
 rtl/fp_add_pipe.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_pipe : 3-stage pipelined floating-point add/sub, RNE, specials bypass
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_overflow,
  output logic             out_invalid
);

  localparam int MW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] SH_LIM   = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- stage 1: classify, swap, align ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_nan, b_nan, a_inf, b_inf;
  logic [W-2:0]     a_mag, b_mag;
  logic             swap;

  assign a_sign = in_a[W-1];
  assign b_sign = in_b[W-1] ^ in_sub;
  assign a_exp  = in_a[W-2:MAN_W];
  assign b_exp  = in_b[W-2:MAN_W];
  assign a_frac = in_a[MAN_W-1:0];
  assign b_frac = in_b[MAN_W-1:0];
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  // Denormals compare as zero so they lose the swap and flush cleanly
  assign a_mag  = (a_exp == '0) ? '0 : in_a[W-2:0];
  assign b_mag  = (b_exp == '0) ? '0 : in_b[W-2:0];
  assign swap   = b_mag > a_mag;

  logic             big_sign;
  logic [EXP_W-1:0] big_exp, lit_exp, exp_diff;
  logic [MW-1:0]    big_man, lit_man, lit_al;
  logic             spec, spec_inv;
  logic [W-1:0]     spec_val;

  always_comb begin
    big_sign = swap ? b_sign : a_sign;
    big_exp  = swap ? b_exp  : a_exp;
    lit_exp  = swap ? a_exp  : b_exp;
    big_man  = swap ? ((b_exp == '0) ? '0 : {1'b1, b_frac, 3'b000})
                    : ((a_exp == '0) ? '0 : {1'b1, a_frac, 3'b000});
    lit_man  = swap ? ((a_exp == '0) ? '0 : {1'b1, a_frac, 3'b000})
                    : ((b_exp == '0) ? '0 : {1'b1, b_frac, 3'b000});
    exp_diff = big_exp - lit_exp;
    if (exp_diff >= SH_LIM) begin
      lit_al = {{(MW-1){1'b0}}, |lit_man};
    end else begin
      lit_al    = lit_man >> exp_diff;
      lit_al[0] = lit_al[0] | (|(lit_man & ~({MW{1'b1}} << exp_diff)));
    end

    spec     = 1'b0;
    spec_inv = 1'b0;
    spec_val = QNAN;
    if (a_nan || b_nan) begin
      spec     = 1'b1;
      spec_inv = 1'b1;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec     = 1'b1;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec     = 1'b1;
      spec_val = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec     = 1'b1;
      spec_val = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid;
  logic             s1_sign, s1_eff_sub, s1_spec, s1_spec_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_big, s1_lit;
  logic [W-1:0]     s1_spec_val;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign     <= big_sign;
      s1_eff_sub  <= a_sign ^ b_sign;
      s1_exp      <= big_exp;
      s1_big      <= big_man;
      s1_lit      <= lit_al;
      s1_spec     <= spec;
      s1_spec_inv <= spec_inv;
      s1_spec_val <= spec_val;
      s1_tag      <= in_tag;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic [SW-1:0] sum;
  assign sum = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_lit})
                          : ({1'b0, s1_big} + {1'b0, s1_lit});

  logic             s2_valid;
  logic             s2_sign, s2_eff_sub, s2_spec, s2_spec_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  logic [W-1:0]     s2_spec_val;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s2_sign     <= s1_sign;
      s2_eff_sub  <= s1_eff_sub;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
      s2_spec     <= s1_spec;
      s2_spec_inv <= s1_spec_inv;
      s2_spec_val <= s1_spec_val;
      s2_tag      <= s1_tag;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  function automatic logic [LZW-1:0] clz(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = LZW'(MW);
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZW'(MW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [LZW-1:0]   lzc;
  logic [MW-1:0]    norm;
  logic [EW-1:0]    e_norm, e_rnd;
  logic             rnd_up;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res;
  logic             res_ovf, res_inv;

  always_comb begin
    lzc = clz(s2_sum[MW-1:0]);
    if (s2_sum[SW-1]) begin
      norm   = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      e_norm = EW'(s2_exp) + EW'(1);
    end else begin
      norm   = s2_sum[MW-1:0] << lzc;
      e_norm = EW'(s2_exp) - EW'(lzc);
    end

    // Nearest-even: round up above half, or on exact half when LSB is odd
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(rnd_up);
    if (rounded[MAN_W+1]) begin
      frac  = rounded[MAN_W:1];
      e_rnd = e_norm + EW'(1);
    end else begin
      frac  = rounded[MAN_W-1:0];
      e_rnd = e_norm;
    end

    res_ovf = 1'b0;
    res_inv = 1'b0;
    if (s2_spec) begin
      res     = s2_spec_val;
      res_inv = s2_spec_inv;
    end else if (s2_sum == '0) begin
      res = {s2_eff_sub ? 1'b0 : s2_sign, {(W-1){1'b0}}};
    end else if (e_rnd[EW-1] || (e_rnd == '0)) begin
      res = {s2_sign, {(W-1){1'b0}}};
    end else if (e_rnd >= EW'(EXP_ONES)) begin
      res     = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else begin
      res = {s2_sign, e_rnd[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_tag      <= '0;
      out_overflow <= 1'b0;
      out_invalid  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sum      <= res;
        out_tag      <= s2_tag;
        out_overflow <= res_ovf;
        out_invalid  <= res_inv;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_add_pipe : directed-vector bench for fp_add_pipe (FP32 configuration)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_add_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_overflow;
  logic        out_invalid;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_tag      (out_tag),
    .out_overflow (out_overflow),
    .out_invalid  (out_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        ovf;
    logic        inv;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [3:0] tag);
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // One isolated operation with out_ready held high; checks latency and result
  task automatic issue_and_check(input vec_t v, input logic [3:0] tag);
    int lat;
    @(negedge clk);
    drive(v, tag);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd3);
    chk("sum", out_sum, v.sum);
    chk("tag", {28'b0, out_tag}, {28'b0, tag});
    chk("overflow", {31'b0, out_overflow}, {31'b0, v.ovf});
    chk("invalid", {31'b0, out_invalid}, {31'b0, v.inv});
  endtask

  initial begin
    int  pidx, cidx, cyc;
    logic held;
    logic [31:0] held_sum;
    logic [3:0]  held_tag;
    logic in_fire, out_fire;

    //           a             b             sub   sum           ovf   inv
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    vecs[5]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0};
    vecs[6]  = '{32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 1'b0, 1'b0};
    vecs[7]  = '{32'h3FFFFFFF, 32'h34000000, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
    vecs[11] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[12] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0};
    vecs[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1};
    vecs[15] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[16] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0};
    vecs[17] = '{32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[18] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[19] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0};
    vecs[20] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
    chk("rst_flags", {30'b0, out_overflow, out_invalid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue_and_check(vecs[i], 4'(i));
    end

    // Back-to-back stream with a forced stall window plus random backpressure
    @(negedge clk);
    pidx = 0; cidx = 0; cyc = 0; held = 1'b0;
    held_sum = '0; held_tag = '0;
    while (cidx < 8 && cyc < 200) begin
      out_ready = (cyc >= 4 && cyc <= 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (pidx < 8) drive(vecs[pidx], 4'(pidx));
      else          in_valid = 1'b0;
      #1;
      if (held) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_sum", out_sum, held_sum);
        chk("hold_tag", {28'b0, out_tag}, {28'b0, held_tag});
      end
      chk("in_ready_en", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      held     = out_valid && !out_ready;
      held_sum = out_sum;
      held_tag = out_tag;
      if (out_fire) begin
        chk("stream_tag", {28'b0, out_tag}, 32'(cidx));
        chk("stream_sum", out_sum, vecs[cidx].sum);
        cidx++;
      end
      if (in_fire) pidx++;
      cyc++;
      @(negedge clk);
    end
    chk("stream_complete", 32'(cidx), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_duplicate", {31'b0, out_valid}, 32'd0);
    end

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive(vecs[i], 4'(i + 8));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("inflight_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_sum", out_sum, 32'd0);
    chk("async_rst_tag", {28'b0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", {31'b0, out_valid}, 32'd0);
    end
    issue_and_check(vecs[4], 4'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
